coproc_sequencer: RTL and testbench

//   Command sequencer in front of the crypto engines. Takes the 32-bit instruction word stream
//   (header + payload words), selects one of NUM_ENG engines, starts it, streams the payload to it

---
 rtl/coproc_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_coproc_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_sequencer.sv
// rtl/coproc_sequencer.sv - command sequencer: decodes headers, starts one engine, feeds payload, captures result
module coproc_sequencer #(
  parameter int NUM_ENG        = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  output logic                   instr_ready,
  output logic [NUM_ENG-1:0]     eng_sel,
  output logic                   eng_start,
  output logic [3:0]             eng_func,
  output logic [7:0]             eng_len,
  output logic [31:0]            eng_data,
  output logic                   eng_data_valid,
  input  logic                   eng_data_ready,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [32*NUM_ENG-1:0]  eng_result,
  output logic [31:0]            out,
  output logic                   busy,
  output logic                   err
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMO_M1 = TIMEOUT_CYCLES - 1;
  localparam int ENG_N  = NUM_ENG;
  localparam logic [TW-1:0] TMO_LAST  = TMO_M1[TW-1:0];
  localparam logic [2:0]    NUM_ENG_W = ENG_N[2:0];
  localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_START, S_FEED, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    id_q, id_d;
  logic [3:0]    func_q, func_d;
  logic [7:0]    len_q, len_d;
  logic [6:0]    words_q, words_d;
  logic [6:0]    win_q, win_d;
  logic [6:0]    wout_q, wout_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   out_q, out_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          is_hdr, id_ok;
  logic [6:0]    hdr_words;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic          done_sel;
  logic [31:0]   res_sel;

  assign is_hdr     = (instr[31:30] == 2'b01);
  assign id_ok      = ({1'b0, instr[29:28]} < NUM_ENG_W);
  // Round byte length up to whole words: ceil(len/4) without a 9-bit adder.
  assign hdr_words  = {1'b0, instr[7:2]} + {6'd0, |instr[1:0]};
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  always_comb begin
    done_sel = 1'b0;
    res_sel  = '0;
    eng_sel  = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (id_q == k[1:0]) begin
        done_sel   = eng_done[k];
        res_sel    = eng_result[32*k +: 32];
        eng_sel[k] = (state_q != S_IDLE);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    func_d         = func_q;
    len_d          = len_q;
    words_d        = words_q;
    win_d          = win_q;
    wout_d         = wout_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    tmo_d          = tmo_q;
    out_d          = out_q;
    err_d          = err_q;
    instr_ready    = 1'b0;
    eng_start      = 1'b0;
    eng_data_valid = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && (instr != 32'd0)) begin
          if (is_hdr && id_ok) begin
            id_d    = instr[29:28];
            func_d  = instr[27:24];
            len_d   = instr[7:0];
            words_d = hdr_words;
            err_d   = 1'b0;
            state_d = S_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_START: begin
        eng_start = 1'b1;
        win_d     = '0;
        wout_d    = '0;
        tmo_d     = '0;
        state_d   = (words_q != 7'd0) ? S_FEED : S_WAIT;
      end

      S_FEED: begin
        instr_ready    = !fifo_full && (win_q < words_q);
        eng_data_valid = !fifo_empty;
        push           = instr_valid && instr_ready;
        pop            = eng_data_valid && eng_data_ready;
        if (push) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          win_d    = win_q + 7'd1;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          wout_d   = wout_q + 7'd1;
        end
        case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        if (wout_d == words_q) state_d = S_WAIT;
      end

      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (done_sel) begin
          out_d   = res_sel;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      func_q   <= '0;
      len_q    <= '0;
      words_q  <= '0;
      win_q    <= '0;
      wout_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      func_q   <= func_d;
      len_q    <= len_d;
      words_q  <= words_d;
      win_q    <= win_d;
      wout_q   <= wout_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= instr;
  end

  assign eng_data = mem_q[rd_ptr_q];
  assign eng_func = func_q;
  assign eng_len  = len_q;
  assign out      = out_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// tb/tb_coproc_sequencer.sv - scoreboard bench for coproc_sequencer with directed command vectors
module tb_coproc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [1:0]  eng_sel;
  logic        eng_start;
  logic [3:0]  eng_func;
  logic [7:0]  eng_len;
  logic [31:0] eng_data;
  logic        eng_data_valid;
  logic        eng_data_ready;
  logic [1:0]  eng_done;
  logic [63:0] eng_result;
  logic [31:0] out;
  logic        busy;
  logic        err;

  coproc_sequencer #(.NUM_ENG(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .eng_sel(eng_sel), .eng_start(eng_start), .eng_func(eng_func), .eng_len(eng_len),
    .eng_data(eng_data), .eng_data_valid(eng_data_valid), .eng_data_ready(eng_data_ready),
    .eng_done(eng_done), .eng_result(eng_result),
    .out(out), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_start_q [$];
  logic [31:0] exp_data_q  [$];
  logic [32:0] exp_end_q   [$];
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] start_word(input logic [1:0] sel, input logic [3:0] func,
                                             input logic [7:0] len);
    return {18'd0, sel, func, len};
  endfunction

  // Monitor: every start pulse, data beat and command completion is matched to the queues.
  always @(negedge clock) begin
    if (reset) begin
      busy_prev = 1'b0;
    end else begin
      if (eng_start) begin
        if (exp_start_q.size() == 0) check("start_extra_pending", exp_start_q.size(), 1);
        else check("start_fields", {18'd0, eng_sel, eng_func, eng_len}, exp_start_q.pop_front());
      end
      if (eng_data_valid && eng_data_ready) begin
        if (exp_data_q.size() == 0) check("beat_extra_pending", exp_data_q.size(), 1);
        else check("beat_data", eng_data, exp_data_q.pop_front());
      end
      if (busy_prev && !busy) begin
        if (exp_end_q.size() == 0) check("end_extra_pending", exp_end_q.size(), 1);
        else begin
          logic [32:0] e;
          e = exp_end_q.pop_front();
          check("end_out", out, e[31:0]);
          check("end_err", {31'd0, err}, {31'd0, e[32]});
        end
      end
      busy_prev = busy;
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr       = w;
    @(negedge clock);
    while (!instr_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    check("send_accepted", {31'd0, instr_ready}, 32'd1);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clock);
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic finish_cmd(input logic [1:0] mask, input int eng, input logic [31:0] res,
                            input int delay);
    int n;
    repeat (delay) @(posedge clock);
    #1;
    eng_result[eng*32 +: 32] = res;
    eng_done = mask;
    wait_idle(n);
    eng_done = '0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    instr_valid    = 1'b0;
    instr          = '0;
    eng_data_ready = 1'b0;
    eng_done       = '0;
    eng_result     = '0;

    @(negedge clock);
    check("rst_out", out, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_eng_sel", {30'd0, eng_sel}, 32'd0);
    check("rst_eng_start", {31'd0, eng_start}, 32'd0);
    check("rst_eng_func", {28'd0, eng_func}, 32'd0);
    check("rst_eng_len", {24'd0, eng_len}, 32'd0);
    check("rst_data_valid", {31'd0, eng_data_valid}, 32'd0);
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;

    // 1: single 4-byte payload on engine 0
    eng_data_ready = 1'b1;
    exp_start_q.push_back(start_word(2'b01, 4'h0, 8'd4));
    exp_data_q.push_back(32'h0061_6263);
    exp_end_q.push_back({1'b0, 32'hA999_3E36});
    send_word(32'h4000_0004);
    send_word(32'h0061_6263);
    finish_cmd(2'b01, 0, 32'hA999_3E36, 10);
    check("t1_sel_cleared", {30'd0, eng_sel}, 32'd0);
    check("t1_len_kept", {24'd0, eng_len}, 32'd4);

    // 2: 7 bytes -> 2 words; extra word refused; engine ready toggling
    eng_data_ready = 1'b0;
    exp_start_q.push_back(start_word(2'b01, 4'h0, 8'd7));
    exp_data_q.push_back(32'h0000_00C4);
    exp_data_q.push_back(32'h0000_0000);
    exp_end_q.push_back({1'b0, 32'h1234_5678});
    send_word(32'h4000_0007);
    send_word(32'h0000_00C4);
    send_word(32'h0000_0000);
    instr_valid = 1'b1;
    instr       = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clock);
      check("t2_extra_refused", {31'd0, instr_ready}, 32'd0);
    end
    check("t2_data_valid", {31'd0, eng_data_valid}, 32'd1);
    instr_valid = 1'b0;
    instr       = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1 eng_data_ready = i[0];
    end
    @(negedge clock);
    check("t2_waiting_busy", {31'd0, busy}, 32'd1);
    check("t2_waiting_ready", {31'd0, instr_ready}, 32'd0);
    finish_cmd(2'b01, 0, 32'h1234_5678, 2);

    // 3: 8 words through a 4-deep FIFO with backpressure; early done must be ignored
    eng_data_ready = 1'b0;
    exp_start_q.push_back(start_word(2'b01, 4'h0, 8'h20));
    for (int i = 1; i <= 8; i++) exp_data_q.push_back(32'h3000_0000 + i);
    exp_end_q.push_back({1'b0, 32'hCAFE_F00D});
    send_word(32'h4000_0020);
    for (int i = 1; i <= 4; i++) send_word(32'h3000_0000 + i);
    instr_valid = 1'b1;
    instr       = 32'h3000_0005;
    eng_done    = 2'b01;
    repeat (2) begin
      @(negedge clock);
      check("t3_full_refused", {31'd0, instr_ready}, 32'd0);
    end
    eng_done = 2'b00;
    @(negedge clock);
    check("t3_early_done_ignored", {31'd0, busy}, 32'd1);
    eng_data_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send_word(32'h3000_0000 + i);
    finish_cmd(2'b01, 0, 32'hCAFE_F00D, 3);

    // 4: bad engine id, then zero-length command on engine 1
    send_word(32'h7000_0004);
    @(negedge clock);
    check("t4_err_set", {31'd0, err}, 32'd1);
    check("t4_stay_idle", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    exp_start_q.push_back(start_word(2'b10, 4'h0, 8'd0));
    exp_end_q.push_back({1'b0, 32'h0BAD_BEEF});
    send_word(32'h5000_0000);
    @(negedge clock);
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    check("t4_sel", {30'd0, eng_sel}, 32'd2);
    eng_result[31:0] = 32'hFFFF_FFFF;
    eng_done = 2'b01;
    repeat (3) @(negedge clock);
    check("t4_wrong_done_ignored", {31'd0, busy}, 32'd1);
    finish_cmd(2'b10, 1, 32'h0BAD_BEEF, 0);

    // 5: timeout, result must stay at previous value
    exp_start_q.push_back(start_word(2'b01, 4'h0, 8'd0));
    exp_end_q.push_back({1'b1, 32'h0BAD_BEEF});
    send_word(32'h4000_0000);
    wait_idle(n);
    check("t5_busy_cycles", n, 17);
    @(posedge clock);
    #1;

    // 6: reset mid-FEED with two words queued, then a normal command
    eng_data_ready = 1'b0;
    exp_start_q.push_back(start_word(2'b01, 4'h0, 8'd16));
    send_word(32'h4000_0010);
    send_word(32'h6666_0001);
    send_word(32'h6666_0002);
    @(negedge clock);
    check("t6_pre_valid", {31'd0, eng_data_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, eng_data_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_sel", {30'd0, eng_sel}, 32'd0);
    check("t6_rst_len", {24'd0, eng_len}, 32'd0);
    check("t6_rst_out", out, 32'd0);
    check("t6_rst_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    eng_data_ready = 1'b1;
    exp_start_q.push_back(start_word(2'b01, 4'h1, 8'd4));
    exp_data_q.push_back(32'h55AA_55AA);
    exp_end_q.push_back({1'b0, 32'h600D_F00D});
    send_word(32'h4100_0004);
    send_word(32'h55AA_55AA);
    finish_cmd(2'b01, 0, 32'h600D_F00D, 4);

    check("drain_start_q", exp_start_q.size(), 0);
    check("drain_data_q", exp_data_q.size(), 0);
    check("drain_end_q", exp_end_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
